// File: rtl/mem_pkg.sv
// Shared constants and encodings for the memory arbiter: line geometry,
// FSM state codes and grant identifiers.
package mem_pkg;

  localparam int ADDR_W = 14;  // line address (16-bit word address minus 2 offset bits)
  localparam int LINE_W = 64;  // 4 x 16-bit words

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MEM  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory handshake seen by the
// arbiter. slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if;
  import mem_pkg::*;

  // I-cache fill port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  // D-cache fill/writeback port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  // shared fill return
  logic [LINE_W-1:0] fill_data;
  // memory handshake
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rdy;
  // status
  logic              idle;
  logic              tmo_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_done, d_done, fill_data, mem_re, mem_we, mem_addr, mem_wdata,
           idle, tmo_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_done, d_done, fill_data, mem_re, mem_we, mem_addr, mem_wdata,
           idle, tmo_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the unified main memory between the I-cache line-fill path and
// the D-cache fill/writeback path. One line transaction at a time; ties go to
// the requester that did not win last. All outputs except idle are registered.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15  // MEM cycles without mem_rdy before tmo_err
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_reg;
  gnt_t              gnt_reg;
  gnt_t              last_gnt_reg;
  logic              i_done_reg;
  logic              d_done_reg;
  logic              mem_re_reg;
  logic              mem_we_reg;
  logic              tmo_err_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [LINE_W-1:0] mem_wdata_reg;
  logic [LINE_W-1:0] fill_data_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  gnt_t              arb_gnt;

  // Pick the winner for this IDLE cycle: a lone requester wins, a tie goes
  // to the side opposite the previous grant.
  always_comb begin
    arb_gnt = GNT_I;
    if (bus.i_req && bus.d_req) begin
      arb_gnt = (last_gnt_reg == GNT_I) ? GNT_D : GNT_I;
    end else if (bus.d_req) begin
      arb_gnt = GNT_D;
    end
  end

  // Transaction FSM: IDLE grants and launches, MEM waits for mem_rdy (with a
  // saturating wait counter that counts the current MEM cycle), DONE pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= GNT_I;
      last_gnt_reg  <= GNT_I;
      i_done_reg    <= 1'b0;
      d_done_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      tmo_err_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      fill_data_reg <= '0;
      wait_cnt_reg  <= '0;
    end else begin
      i_done_reg <= 1'b0;
      d_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            gnt_reg       <= arb_gnt;
            last_gnt_reg  <= arb_gnt;
            mem_addr_reg  <= (arb_gnt == GNT_D) ? bus.d_addr : bus.i_addr;
            mem_wdata_reg <= bus.d_wdata;
            mem_we_reg    <= (arb_gnt == GNT_D) && bus.d_we;
            mem_re_reg    <= (arb_gnt == GNT_I) || !bus.d_we;
            wait_cnt_reg  <= CNT_ONE;
            state_reg     <= MEM;
          end
        end
        MEM: begin
          if (bus.mem_rdy) begin
            // writes leave the last fill line untouched
            if (mem_re_reg) begin
              fill_data_reg <= bus.mem_rdata;
            end
            mem_re_reg   <= 1'b0;
            mem_we_reg   <= 1'b0;
            wait_cnt_reg <= '0;
            i_done_reg   <= (gnt_reg == GNT_I);
            d_done_reg   <= (gnt_reg == GNT_D);
            state_reg    <= DONE;
          end else if (wait_cnt_reg != CNT_MAX) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
            if ((wait_cnt_reg + CNT_ONE) == CNT_MAX) begin
              tmo_err_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // idle qualifies halt, so it must reflect a request arriving this cycle.
  assign bus.idle      = (state_reg == IDLE) && !bus.i_req && !bus.d_req;
  assign bus.i_done    = i_done_reg;
  assign bus.d_done    = d_done_reg;
  assign bus.fill_data = fill_data_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.tmo_err   = tmo_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, timeout and
// mid-transaction reset sequences, then randomized traffic against a
// transaction-level model of requesters and memory.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [LINE_W-1:0] exp_fill = '0;
  bit last_d = 1'b0;  // model of the previous grant (1 = D)

  // memory contents seen by the random phase
  logic [LINE_W-1:0] mem_model [logic [ADDR_W-1:0]];

  typedef struct {
    bit                i_req;
    bit                d_req;
    bit                d_we;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] rdata;
    int                lat;
    bit                first_d;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [LINE_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {2'b00, a, 2'b01, ~a, 16'h1234, a, 2'b10};
  endfunction

  // Advance until a memory strobe appears, bounded.
  task automatic wait_strobe(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.mem_re || bus.mem_we) && n < 8);
    check({name, "_grant"}, 64'(bus.mem_re | bus.mem_we), 64'(1));
  endtask

  // Called at the negedge of the first MEM cycle (or any later MEM cycle):
  // checks the launch, supplies mem_rdy after lat cycles, checks the done pulse.
  task automatic serve(input string name, input bit exp_d, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                       input logic [LINE_W-1:0] rdata, input int lat);
    check({name, "_re"}, 64'(bus.mem_re), 64'(!we));
    check({name, "_we"}, 64'(bus.mem_we), 64'(we));
    check({name, "_addr"}, 64'(bus.mem_addr), 64'(addr));
    if (we) check({name, "_wdata"}, bus.mem_wdata, wdata);
    last_d = exp_d;
    for (int k = 0; k < lat; k++) begin
      tick();
      check({name, "_hold"}, 64'({bus.mem_re, bus.mem_we, bus.mem_addr}), 64'({!we, we, addr}));
      check({name, "_early_done"}, 64'(bus.i_done | bus.d_done), 64'(0));
    end
    bus.mem_rdy   = 1'b1;
    bus.mem_rdata = rdata;
    if (!we) exp_fill = rdata;
    tick();
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = {$urandom, $urandom};
    check({name, "_i_done"}, 64'(bus.i_done), 64'(!exp_d));
    check({name, "_d_done"}, 64'(bus.d_done), 64'(exp_d));
    check({name, "_strobe_off"}, 64'(bus.mem_re | bus.mem_we), 64'(0));
    check({name, "_fill"}, bus.fill_data, exp_fill);
    $display("txn %s: gnt=%s we=%0d addr=%h fill=%h", name, exp_d ? "D" : "I", we, addr, bus.fill_data);
    if (exp_d) bus.d_req = 1'b0;
    else bus.i_req = 1'b0;
    tick();
    check({name, "_pulse_one"}, 64'(bus.i_done | bus.d_done), 64'(0));
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 14'h0123, 14'h0000, 64'h0, 64'hDEAD_BEEF_0123_4567, 4, 0};
    tbl[1] = '{1, 1, 1, 14'h0155, 14'h0040, 64'h1111_1111_1111_1111, 64'hCAFE_0000_1234_5678, 1, 1};
    tbl[2] = '{1, 1, 0, 14'h0156, 14'h0041, 64'h2222_2222_2222_2222, 64'h0BAD_F00D_9999_0001, 2, 1};
    tbl[3] = '{0, 1, 1, 14'h0000, 14'h0200, 64'hA5A5_A5A5_A5A5_A5A5, 64'h7777_7777_7777_7777, 0, 1};
    tbl[4] = '{0, 1, 0, 14'h0000, 14'h0200, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 0, 1};
    tbl[5] = '{1, 1, 0, 14'h0301, 14'h0300, 64'h0, 64'h1357_9BDF_2468_ACE0, 3, 0};
    tbl[6] = '{1, 0, 0, 14'h3FFF, 14'h0000, 64'h0, 64'hFFFF_0000_FFFF_0000, 0, 0};
    tbl[7] = '{0, 1, 1, 14'h0000, 14'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2, 1};

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdy = 1'b0; bus.mem_rdata = '0;

    // reset state
    repeat (3) tick();
    check("rst_idle", 64'(bus.idle), 64'(1));
    check("rst_strobes", 64'({bus.mem_re, bus.mem_we}), 64'(0));
    check("rst_done", 64'({bus.i_done, bus.d_done}), 64'(0));
    check("rst_tmo", 64'(bus.tmo_err), 64'(0));
    check("rst_fill", bus.fill_data, 64'(0));
    check("rst_addr", 64'(bus.mem_addr), 64'(0));
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 64'(bus.idle), 64'(1));

    // directed vector table
    for (int r = 0; r < 8; r++) begin
      bit fd;
      bus.i_addr  = tbl[r].i_addr;
      bus.d_addr  = tbl[r].d_addr;
      bus.d_we    = tbl[r].d_we;
      bus.d_wdata = tbl[r].d_wdata;
      bus.i_req   = tbl[r].i_req;
      bus.d_req   = tbl[r].d_req;
      fd = tbl[r].first_d;
      wait_strobe($sformatf("v%0d", r));
      serve($sformatf("v%0d_a", r), fd, fd && tbl[r].d_we,
            fd ? tbl[r].d_addr : tbl[r].i_addr, tbl[r].d_wdata, tbl[r].rdata, tbl[r].lat);
      if (tbl[r].i_req && tbl[r].d_req) begin
        wait_strobe($sformatf("v%0d_b", r));
        serve($sformatf("v%0d_b", r), !fd, !fd && tbl[r].d_we,
              !fd ? tbl[r].d_addr : tbl[r].i_addr, tbl[r].d_wdata, ~tbl[r].rdata, tbl[r].lat);
      end
    end

    // timeout: mem_rdy withheld, flag appears in the 15th MEM cycle
    bus.i_addr = 14'h0777;
    bus.i_req  = 1'b1;
    wait_strobe("tmo");
    check("tmo_mem1", 64'(bus.tmo_err), 64'(0));
    for (int k = 2; k <= 14; k++) tick();
    check("tmo_mem14", 64'(bus.tmo_err), 64'(0));
    tick();
    check("tmo_mem15", 64'(bus.tmo_err), 64'(1));
    for (int k = 16; k <= 20; k++) tick();
    check("tmo_still_mem", 64'({bus.mem_re, bus.i_done}), 64'(2'b10));
    serve("tmo_fin", 1'b0, 1'b0, 14'h0777, bus.d_wdata, 64'h0F0F_1E1E_2D2D_3C3C, 0);
    check("tmo_sticky", 64'(bus.tmo_err), 64'(1));

    // reset mid-transaction
    bus.d_we   = 1'b0;
    bus.d_addr = 14'h0500;
    bus.d_req  = 1'b1;
    wait_strobe("rmid");
    #2 rst_n = 1'b0;
    #1;
    check("rmid_re_async", 64'(bus.mem_re), 64'(0));
    check("rmid_tmo_clr", 64'(bus.tmo_err), 64'(0));
    check("rmid_idle", 64'(bus.idle), 64'(0));
    tick();
    check("rmid_no_done", 64'(bus.i_done | bus.d_done), 64'(0));
    rst_n    = 1'b1;
    last_d   = 1'b0;
    exp_fill = '0;
    check("rmid_fill_clr", bus.fill_data, exp_fill);
    wait_strobe("reissue");
    serve("reissue", 1'b1, 1'b0, 14'h0500, bus.d_wdata, 64'h8642_0000_ACE1_BDF3, 2);

    // randomized traffic against the transaction model
    begin : rand_phase
      bit busy;
      bit gnt_d;
      bit cur_we;
      bit rdy_real;
      bit drop_i;
      bit drop_d;
      bit win_d;
      int cnt;
      int stall;
      int done_cnt;
      logic [ADDR_W-1:0] cur_addr;
      logic [LINE_W-1:0] cur_wdata;
      busy = 0; gnt_d = 0; cur_we = 0; rdy_real = 0;
      cnt = 0; stall = 0; done_cnt = 0;
      cur_addr = '0; cur_wdata = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        tick();
        drop_i = 0;
        drop_d = 0;
        check("r_excl", 64'(bus.mem_re & bus.mem_we), 64'(0));
        check("r_idle", 64'(bus.idle), 64'(!busy && !bus.i_req && !bus.d_req));
        check("r_i_done", 64'(bus.i_done), 64'(rdy_real && !gnt_d));
        check("r_d_done", 64'(bus.d_done), 64'(rdy_real && gnt_d));
        check("r_fill", bus.fill_data, exp_fill);
        check("r_tmo", 64'(bus.tmo_err), 64'(0));
        if (rdy_real) begin
          check("r_strobe_off", 64'(bus.mem_re | bus.mem_we), 64'(0));
          $display("txn rand%0d: gnt=%s we=%0d addr=%h fill=%h", done_cnt,
                   gnt_d ? "D" : "I", cur_we, cur_addr, bus.fill_data);
          busy = 0;
          done_cnt++;
          if (gnt_d) begin bus.d_req = 1'b0; drop_d = 1; end
          else begin bus.i_req = 1'b0; drop_i = 1; end
        end else if (busy) begin
          check("r_hold", 64'({bus.mem_re, bus.mem_we, bus.mem_addr}), 64'({!cur_we, cur_we, cur_addr}));
        end else if (bus.mem_re || bus.mem_we) begin
          check("r_req_present", 64'(bus.i_req | bus.d_req), 64'(1));
          win_d     = (bus.i_req && bus.d_req) ? !last_d : bus.d_req;
          cur_we    = win_d && bus.d_we;
          cur_addr  = win_d ? bus.d_addr : bus.i_addr;
          cur_wdata = bus.d_wdata;
          check("r_grant", 64'({bus.mem_re, bus.mem_we, bus.mem_addr}), 64'({!cur_we, cur_we, cur_addr}));
          if (cur_we) check("r_wdata", bus.mem_wdata, cur_wdata);
          busy   = 1;
          gnt_d  = win_d;
          last_d = win_d;
          cnt    = $urandom_range(0, 4);
          stall  = 0;
        end else begin
          if (bus.i_req || bus.d_req) stall++;
          else stall = 0;
          check("r_no_stall", 64'(stall > 1), 64'(0));
        end
        // memory side
        rdy_real      = 0;
        bus.mem_rdy   = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
        if (busy) begin
          if (cnt == 0) begin
            bus.mem_rdy = 1'b1;
            rdy_real    = 1;
            if (cur_we) mem_model[cur_addr] = cur_wdata;
            else begin
              bus.mem_rdata = mem_read(cur_addr);
              exp_fill      = bus.mem_rdata;
            end
          end else begin
            cnt--;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          bus.mem_rdy = 1'b1;  // stray pulse outside MEM
        end
        // requesters
        if (!bus.i_req && !drop_i && $urandom_range(0, 2) == 0) begin
          bus.i_addr = 14'($urandom_range(0, 7));
          bus.i_req  = 1'b1;
        end
        if (!bus.d_req && !drop_d && $urandom_range(0, 2) == 0) begin
          bus.d_addr  = 14'($urandom_range(0, 7));
          bus.d_we    = 1'($urandom_range(0, 1));
          bus.d_wdata = {$urandom, $urandom};
          bus.d_req   = 1'b1;
        end
      end
      check("r_progress", 64'(done_cnt >= 100), 64'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
